// File: rtl/ddr_bridge_pkg.sv
// Shared definitions for the CPU-to-DDR request bridge: bridge FSM states
// and the memory-controller state encodings the bridge reacts to.
package ddr_bridge_pkg;

    localparam logic [3:0] MEM_ST_INIT = 4'd0;
    localparam logic [3:0] MEM_ST_IDLE = 4'd1;

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_IDLE     = 3'd1,
        S_WR_ISSUE = 3'd2,
        S_WR_WAIT  = 3'd3,
        S_RD_DRAIN = 3'd4,
        S_RD_ISSUE = 3'd5,
        S_RD_WAIT  = 3'd6,
        S_RD_DONE  = 3'd7
    } bridge_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Write buffer: synchronous FIFO of {word address, data} pairs.
// Pointers wrap naturally because DEPTH is a power of two. Storage is not
// reset; clearing the pointers and count empties the buffer.
module wb_fifo
    import ddr_bridge_pkg::*;
#(
    parameter int AW    = 27,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          iCLK,
    input  logic          iRST_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign count     = cnt;
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge iCLK) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ddr_req_bridge.sv
// CPU load/store to DDR controller request bridge with a posted write buffer.
// Stores are buffered and retired in order; a load first drains the buffer
// so it can never overtake an earlier store to the same address.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  S_INIT     | waiting for the controller to finish its own init
//  S_IDLE     | nothing outstanding; pick a load or the buffer head
//  S_WR_ISSUE | mem_write_req with buffer head, wait for controller busy
//  S_WR_WAIT  | write accepted, wait for controller idle, then pop
//  S_RD_DRAIN | load pending; retire buffered writes before reading
//  S_RD_ISSUE | mem_read_req with load address, wait for controller busy
//  S_RD_WAIT  | read accepted, capture data when controller idles
//  S_RD_DONE  | one cycle: return data to the CPU and release the stall
module ddr_req_bridge
    import ddr_bridge_pkg::*;
#(
    parameter int ADDR_W   = 27,
    parameter int DATA_W   = 32,
    parameter int WB_DEPTH = 4
) (
    input  logic                      iCLK,
    input  logic                      iRST_n,
    input  logic                      cpu_rd,
    input  logic                      cpu_wr,
    input  logic [31:0]               cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_stall,
    output logic                      mem_read_req,
    output logic                      mem_write_req,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic [3:0]                mem_c_state,
    output logic [$clog2(WB_DEPTH):0] wb_count
);

    bridge_state_t       state_q;
    bridge_state_t       state_d;
    logic [ADDR_W-1:0]   cpu_word;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   wb_head_addr;
    logic [DATA_W-1:0]   wb_head_data;
    logic                wb_full;
    logic                wb_empty;
    logic                wb_push;
    logic                wb_pop;
    logic                rd_capture;
    logic                mem_idle;

    // Byte lane and unused upper address bits are deliberately dropped.
    wire unused_addr_bits = ^{cpu_addr[1:0], cpu_addr[31:ADDR_W+2]};

    assign cpu_word = cpu_addr[ADDR_W+1:2];
    assign mem_idle = (mem_c_state == MEM_ST_IDLE);

    wb_fifo #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (WB_DEPTH)
    ) u_wb_fifo (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .push      (wb_push),
        .push_addr (cpu_word),
        .push_data (cpu_wdata),
        .pop       (wb_pop),
        .head_addr (wb_head_addr),
        .head_data (wb_head_data),
        .full      (wb_full),
        .empty     (wb_empty),
        .count     (wb_count)
    );

    // State register.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state_q <= S_INIT;
        else         state_q <= state_d;
    end

    // Next-state logic plus the pop and read-capture strobes.
    always_comb begin
        state_d    = state_q;
        wb_pop     = 1'b0;
        rd_capture = 1'b0;
        case (state_q)
            S_INIT:     if (mem_idle) state_d = S_IDLE;
            S_IDLE: begin
                if (cpu_rd)         state_d = S_RD_DRAIN;
                else if (!wb_empty) state_d = S_WR_ISSUE;
            end
            S_WR_ISSUE: if (!mem_idle) state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (mem_idle) begin
                    wb_pop  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RD_DRAIN: state_d = wb_empty ? S_RD_ISSUE : S_WR_ISSUE;
            S_RD_ISSUE: if (!mem_idle) state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (mem_idle) begin
                    rd_capture = 1'b1;
                    state_d    = S_RD_DONE;
                end
            end
            S_RD_DONE:  state_d = S_IDLE;
            default:    state_d = S_INIT;
        endcase
    end

    // CPU handshake: loads win over stores; store admission uses the
    // registered full flag so a same-cycle pop cannot make room.
    always_comb begin
        wb_push   = cpu_wr && !cpu_rd && !wb_full && (state_q != S_INIT);
        cpu_stall = 1'b0;
        if (cpu_rd)      cpu_stall = (state_q != S_RD_DONE);
        else if (cpu_wr) cpu_stall = !wb_push;
    end

    // Memory-side request lines and address/data muxing, zero when idle.
    always_comb begin
        mem_write_req = (state_q == S_WR_ISSUE);
        mem_read_req  = (state_q == S_RD_ISSUE);
        mem_addr      = '0;
        mem_wdata     = '0;
        case (state_q)
            S_WR_ISSUE, S_WR_WAIT: begin
                mem_addr  = wb_head_addr;
                mem_wdata = wb_head_data;
            end
            S_RD_ISSUE, S_RD_WAIT: mem_addr = rd_addr_q;
            default: ;
        endcase
    end

    // Load address latched when the load is taken; read data captured on return.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rd_addr_q <= '0;
            rdata_q   <= '0;
        end else begin
            if (state_q == S_IDLE && cpu_rd) rd_addr_q <= cpu_word;
            if (rd_capture)                  rdata_q   <= mem_rdata;
        end
    end

    assign cpu_rdata = rdata_q;

endmodule

// File: doc/ddr_req_bridge.md
DDR_REQ_BRIDGE -- requirements
Module: ddr_req_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter WB_DEPTH, default 4, write-buffer entries (power of two, at least 2).
REQ-004 SHALL have port iCLK, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port iRST_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports cpu_rd and cpu_wr, input, 1 each, CPU load and store requests, held by the CPU while cpu_stall=1.
REQ-007 SHALL have port cpu_addr, input, 32, CPU byte address.
REQ-008 SHALL have port cpu_wdata, input, DATA_W, store data.
REQ-009 SHALL have port cpu_rdata, output, DATA_W, load data, valid in the cycle a load completes.
REQ-010 SHALL have port cpu_stall, output, 1, combinational; CPU holds its request while it is 1.
REQ-011 SHALL have ports mem_read_req and mem_write_req, output, 1 each, requests to the memory controller.
REQ-012 SHALL have port mem_addr, output, ADDR_W, word address to the controller.
REQ-013 SHALL have port mem_wdata, output, DATA_W, write data to the controller.
REQ-014 SHALL have port mem_rdata, input, DATA_W, controller read data.
REQ-015 SHALL have port mem_c_state, input, 4, controller state (0=INIT, 1=IDLE, others busy).
REQ-016 SHALL have port wb_count, output, $clog2(WB_DEPTH)+1, current write-buffer occupancy.

Function
REQ-017 SHALL map mem_addr to cpu_addr[ADDR_W+1:2]; cpu_addr[1:0] SHALL be ignored.
REQ-018 SHALL implement the FSM S_INIT, S_IDLE, S_WR_ISSUE, S_WR_WAIT, S_RD_DRAIN, S_RD_ISSUE, S_RD_WAIT, S_RD_DONE.
REQ-019 SHALL leave S_INIT for S_IDLE only when mem_c_state==1; cpu_stall SHALL be 1 for any request while in S_INIT.
REQ-020 SHALL accept a store (push {addr,data} to the FIFO) in a cycle with cpu_wr=1, cpu_rd=0, registered wb_count<WB_DEPTH, and state not S_INIT; cpu_stall SHALL be 0 in that cycle.
REQ-021 SHALL hold cpu_stall=1 for a store while the buffer is full; a same-cycle pop SHALL NOT admit the push.
REQ-022 SHALL move from S_IDLE to S_WR_ISSUE when the buffer is non-empty and no load is pending.
REQ-023 SHALL, in S_WR_ISSUE, drive mem_write_req=1 with the head entry on mem_addr/mem_wdata, and move to S_WR_WAIT on mem_c_state!=1.
REQ-024 SHALL, in S_WR_WAIT, drive mem_write_req=0 and hold mem_addr/mem_wdata stable; on mem_c_state==1 it SHALL pop the head and return to S_IDLE.
REQ-025 SHALL give a load (cpu_rd=1) priority over a store; cpu_wr SHALL be ignored when both are asserted.
REQ-026 SHALL send a load to S_RD_DRAIN, which drains all buffered writes and then enters S_RD_ISSUE, so a read never overtakes an earlier store.
REQ-027 SHALL, in S_RD_ISSUE, drive mem_read_req=1 with the load address, and move to S_RD_WAIT on mem_c_state!=1.
REQ-028 SHALL, in S_RD_WAIT, on mem_c_state==1, capture mem_rdata into a register and enter S_RD_DONE.
REQ-029 SHALL, in S_RD_DONE, present the captured data on cpu_rdata with cpu_stall=0 for exactly one cycle, then return to S_IDLE.
REQ-030 SHALL keep cpu_stall=1 for a load in every state except S_RD_DONE.
REQ-031 SHALL never assert mem_read_req and mem_write_req together.
REQ-032 SHALL wrap the FIFO pointers modulo WB_DEPTH; wb_count SHALL reach WB_DEPTH exactly when full.

Reset
REQ-033 SHALL, on iRST_n=0 at any time including mid-transaction, enter S_INIT, clear the FIFO, set wb_count=0, and drive mem_read_req=0, mem_write_req=0, mem_addr=0, mem_wdata=0 and cpu_rdata=0.
REQ-034 SHALL discard any in-flight transaction at reset without retrying it.

Structure
REQ-035 SHALL place the FSM state enum and the constants MEM_ST_INIT=4'd0 and MEM_ST_IDLE=4'd1 in the shared package ddr_bridge_pkg.
REQ-036 SHALL implement the write buffer as sub-module wb_fifo (synchronous FIFO with push/pop/full/empty/count).

Verification
REQ-037 Store 0x0000_0040 with data 0xDEADBEEF to an idle, empty buffer -> no stall, wb_count=1, one mem_write_req with mem_addr=0x10, then wb_count=0.
REQ-038 Five back-to-back stores with WB_DEPTH=4 while the memory is busy -> the 5th store is stalled until the first pop, and all 5 writes are issued in order.
REQ-039 Three stores followed by a load of the 2nd store's address -> all three writes are issued before mem_read_req, and cpu_rdata equals the 2nd store's data.
REQ-040 Load while mem_c_state=0 for 20 cycles -> cpu_stall=1 throughout and no memory request until mem_c_state=1.
REQ-041 cpu_rd and cpu_wr together -> only the read is performed and wb_count is unchanged.
REQ-042 iRST_n pulsed during S_WR_WAIT with wb_count=3 -> request lines drop immediately, wb_count=0, and the FSM is in S_INIT.
